// File: rtl/yuv2rgb_engine.sv
// yuv2rgb_engine: converts a 4:2:2 byte stream (U, Y0, V, Y1) into two
// 24-bit RGB pixels per quad using fixed-point BT.601-style coefficients.
// One shared set of multipliers serves both pixels, since their strobes
// never fall on the same cycle.
module yuv2rgb_engine #(
  parameter int FRAC = 10,
  parameter int K_RV = 1436,
  parameter int K_GU = 352,
  parameter int K_GV = 731,
  parameter int K_BU = 1815
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [7:0]  yuv_in,
  output logic        busy,
  output logic        out_valid,
  output logic [23:0] rgb_out
);

  localparam logic signed [23:0] KRV = 24'(K_RV);
  localparam logic signed [23:0] KGU = 24'(K_GU);
  localparam logic signed [23:0] KGV = 24'(K_GV);
  localparam logic signed [23:0] KBU = 24'(K_BU);
  localparam logic signed [23:0] RND = 24'(1 << (FRAC - 1));

  typedef enum logic [1:0] {PH_U, PH_Y0, PH_V, PH_Y1} phase_t;

  phase_t             phase_q;
  logic [7:0]         u_q, y0_q, v_q, y1_q;
  logic               pend0_q, pend1_q;
  logic               busy_q, valid_q;
  logic [23:0]        rgb_q;
  logic               accept;

  logic [7:0]         y_sel;
  logic signed [23:0] y_w, u_w, v_w;
  logic signed [23:0] r_acc, g_acc, b_acc;
  logic [23:0]        rgb_d;

  // Floor-shift the rounded accumulator and saturate to an 8-bit channel.
  function automatic logic [7:0] clamp8(input logic signed [23:0] acc);
    logic signed [23:0] sh;
    sh = acc >>> FRAC;
    if (sh < 24'sd0)
      return 8'd0;
    else if (sh > 24'sd255)
      return 8'hFF;
    else
      return sh[7:0];
  endfunction

  assign accept    = in_en & ~busy_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign rgb_out   = rgb_q;

  // Shared colour-space arithmetic; luma picks Y1 when pixel 1 is pending.
  always_comb begin
    y_sel = pend1_q ? y1_q : y0_q;
    y_w   = $signed({16'd0, y_sel}) <<< FRAC;
    u_w   = $signed({{16{u_q[7]}}, u_q});
    v_w   = $signed({{16{v_q[7]}}, v_q});
    r_acc = y_w + v_w * KRV + RND;
    g_acc = y_w - u_w * KGU - v_w * KGV + RND;
    b_acc = y_w + u_w * KBU + RND;
    rgb_d = {clamp8(r_acc), clamp8(g_acc), clamp8(b_acc)};
  end

  // Phase FSM, byte capture, bubble insertion and registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_U;
      u_q     <= 8'd0;
      y0_q    <= 8'd0;
      v_q     <= 8'd0;
      y1_q    <= 8'd0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      rgb_q   <= 24'h0;
    end else begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;

      // A pixel flagged on the previous edge is produced on this one.
      if (pend0_q || pend1_q) begin
        rgb_q   <= rgb_d;
        valid_q <= 1'b1;
      end

      if (accept) begin
        case (phase_q)
          PH_U: begin
            u_q     <= yuv_in;
            phase_q <= PH_Y0;
          end
          PH_Y0: begin
            y0_q    <= yuv_in;
            phase_q <= PH_V;
          end
          PH_V: begin
            v_q     <= yuv_in;
            pend0_q <= 1'b1;
            phase_q <= PH_Y1;
          end
          PH_Y1: begin
            // The bubble keeps U/V stable until pixel 1 has used them.
            y1_q    <= yuv_in;
            pend1_q <= 1'b1;
            busy_q  <= 1'b1;
            phase_q <= PH_U;
          end
          default: phase_q <= PH_U;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yuv2rgb_engine.sv
// Bench for yuv2rgb_engine: directed quads with known colours, handshake and
// reset corner cases, then a random stream scored through an expected queue.
module tb_yuv2rgb_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_en = 1'b0;
  logic [7:0]  yuv_in = 8'h00;
  logic        busy, out_valid;
  logic [23:0] rgb_out;

  int checks = 0;
  int passes = 0;
  int strobes = 0;
  int expected_strobes = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  yuv2rgb_engine dut (
    .clk      (clk),
    .reset    (reset),
    .in_en    (in_en),
    .yuv_in   (yuv_in),
    .busy     (busy),
    .out_valid(out_valid),
    .rgb_out  (rgb_out)
  );

  function automatic logic [7:0] sat(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'hFF;
    return 8'(x);
  endfunction

  // Reference conversion in plain integer arithmetic.
  function automatic logic [23:0] model(input logic [7:0] u, input logic [7:0] y,
                                        input logic [7:0] v);
    int su, sv, yi, r, g, b;
    su = int'($signed(u));
    sv = int'($signed(v));
    yi = int'({24'd0, y});
    r  = (yi * 1024 + 1436 * sv + 512) >>> 10;
    g  = (yi * 1024 - 352 * su - 731 * sv + 512) >>> 10;
    b  = (yi * 1024 + 1815 * su + 512) >>> 10;
    return {sat(r), sat(g), sat(b)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %h required %h", tag, obs, expv);
  endtask

  // Present one byte at a negedge and return at the negedge after it is accepted.
  task automatic send(input logic [7:0] b);
    int guard;
    guard  = 0;
    in_en  = 1'b1;
    yuv_in = b;
    while (busy !== 1'b0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) begin
      checks++;
      $error("FAIL busy_timeout: busy=%b required 0", busy);
    end
    @(negedge clk);
    in_en = 1'b0;
  endtask

  task automatic send_quad(input logic [7:0] u, input logic [7:0] y0, input logic [7:0] v,
                           input logic [7:0] y1, input logic [23:0] p0, input logic [23:0] p1);
    exp_q.push_back(p0);
    exp_q.push_back(p1);
    expected_strobes += 2;
    send(u);
    send(y0);
    send(v);
    send(y1);
  endtask

  task automatic send_quad_m(input logic [7:0] u, input logic [7:0] y0, input logic [7:0] v,
                             input logic [7:0] y1);
    send_quad(u, y0, v, y1, model(u, y0, v), model(u, y1, v));
  endtask

  // Every strobe must match the oldest outstanding expected pixel.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      logic [23:0] e;
      strobes++;
      checks++;
      assert (exp_q.size() > 0) passes++;
      else $error("FAIL unexpected_strobe: got rgb %h with no pixel outstanding", rgb_out);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (rgb_out === e) passes++;
        else $error("FAIL pixel: got %h required %h", rgb_out, e);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ru, ry0, rv, ry1;
    int g;

    // Reset state.
    #1 reset = 1'b1;
    #2;
    chk("reset_busy", busy, 1);
    chk("reset_valid", out_valid, 0);
    chk("reset_rgb", rgb_out, 24'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("release_busy_hold", busy, 1);
    @(negedge clk);
    chk("release_busy_fall", busy, 0);

    // Neutral gray with strobe and bubble timing.
    exp_q.push_back(24'h808080);
    exp_q.push_back(24'h808080);
    expected_strobes += 2;
    send(8'h00);
    send(8'h80);
    send(8'h00);
    chk("gray_no_early_strobe", out_valid, 0);
    send(8'h80);
    chk("gray_busy_after_y1", busy, 1);
    chk("gray_p0_strobe", out_valid, 1);
    @(negedge clk);
    chk("gray_busy_one_cycle", busy, 0);
    chk("gray_p1_strobe", out_valid, 1);
    @(negedge clk);
    chk("gray_strobe_ends", out_valid, 0);
    chk("gray_rgb_hold", rgb_out, 24'h808080);

    // Clamping at both ends.
    send_quad(8'h00, 8'h80, 8'h7F, 8'h00, 24'hFF2580, 24'hB20000);
    send_quad(8'h80, 8'h00, 8'h00, 8'hFF, 24'h002C00, 24'hFFFF1C);

    // Garbage held during the bubble must not be captured.
    send_quad_m(8'h10, 8'h50, 8'hF0, 8'hA0);
    chk("hs_busy_bubble", busy, 1);
    in_en  = 1'b1;
    yuv_in = 8'hEE;
    @(negedge clk);
    send_quad_m(8'h20, 8'hC0, 8'h30, 8'h40);

    // in_en dropped mid-quad for three cycles.
    exp_q.push_back(model(8'hE0, 8'h60, 8'h18));
    exp_q.push_back(model(8'hE0, 8'h90, 8'h18));
    expected_strobes += 2;
    send(8'hE0);
    send(8'h60);
    repeat (3) @(negedge clk);
    send(8'h18);
    send(8'h90);
    repeat (3) @(negedge clk);

    // Reset after U,Y0: partial quad discarded.
    send(8'h30);
    send(8'h40);
    reset = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_rgb", rgb_out, 24'h0);
    chk("midrst_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_quad_m(8'h05, 8'h70, 8'hFB, 8'h90);
    repeat (3) @(negedge clk);

    // Reset with pixel 0 pending: its strobe must be cancelled.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("pend_cancel_valid", out_valid, 0);
    send_quad_m(8'hC0, 8'h20, 8'h40, 8'hE0);

    // Random stream.
    for (int i = 0; i < 500; i++) begin
      ru  = 8'($urandom);
      ry0 = 8'($urandom);
      rv  = 8'($urandom);
      ry1 = 8'($urandom);
      send_quad_m(ru, ry0, rv, ry1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    g = 0;
    while (exp_q.size() > 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("strobe_count", strobes, expected_strobes);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/yuv2rgb_engine.md
Name: yuv2rgb_engine

Overview:
- Inverse of the CTE RGB-to-YUV path: consumes a 4:2:2 byte stream ordered U,Y0,V,Y1 on yuv_in and emits two 24-bit RGB pixels per quad.
- Sits on the CTE input side (function 1, YUV-to-RGB).
- Uses the same in_en/busy input handshake and out_valid output strobe as the existing CTE datapath.
- Verified against golden RGB files with the same square-distance scoring flow.

Parameters:
- FRAC, 10, fractional bits of fixed-point coefficients.
- K_RV, 1436, V-to-R coefficient (1.402 x 2^FRAC, rounded).
- K_GU, 352, U-to-G coefficient (0.344 x 2^FRAC).
- K_GV, 731, V-to-G coefficient (0.714 x 2^FRAC).
- K_BU, 1815, U-to-B coefficient (1.772 x 2^FRAC).

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_en, input, 1: yuv_in carries a valid byte this cycle.
- yuv_in, input, 8: stream byte; U and V are signed two's complement, Y is unsigned.
- busy, output, 1: block refuses input this cycle.
- out_valid, output, 1: one-cycle strobe; rgb_out holds a new pixel.
- rgb_out, output, 24: {R[23:16], G[15:8], B[7:0]}, each unsigned 0..255.

Behaviour:
- Reset values (asynchronous): busy=1, out_valid=0, rgb_out=24'h0, phase=PH_U, all capture registers 0.
- After reset deasserts: busy falls to 0 on the first rising edge.
- Accept rule: a byte is accepted on a rising edge only when in_en=1 and busy=0.
  - If busy=1, the byte is ignored; the source must re-present it.
  - If in_en=0, the phase holds.
- Phase FSM advances only on accept: PH_U -> PH_Y0 -> PH_V -> PH_Y1 -> PH_U.
  - Capture registers: U, Y0, V, Y1.
- Busy rule: busy goes to 1 on the edge that accepts Y1, and returns to 0 on the following edge.
  - This gives one bubble per quad: peak throughput is 4 bytes per 5 cycles.
  - busy is a register output, not a combinational function of in_en.
- Pixel 0 (U, Y0, V): rgb_out registered and out_valid=1 on the edge after V is accepted.
- Pixel 1 (U, Y1, V): rgb_out registered and out_valid=1 on the edge after Y1 is accepted.
- out_valid is otherwise 0. rgb_out holds its last value between strobes.
- Arithmetic per channel, with Y = Y0 or Y1 and signed intermediates of at least 20 bits:
  - R = (Y<<FRAC) + K_RV*V + 2^(FRAC-1)
  - G = (Y<<FRAC) - K_GU*U - K_GV*V + 2^(FRAC-1)
  - B = (Y<<FRAC) + K_BU*U + 2^(FRAC-1)
  - Then arithmetic shift right by FRAC (floor), then clamp: results <0 become 0, results >255 become 255.
- U and V are sign-extended from 8 bits: 8'h80 = -128, 8'h7F = +127. Y is zero-extended.
- Multiplier sharing across cycles is allowed, provided the strobe timing above is preserved exactly.
- Reset asserted mid-quad: partial quad discarded, phase returns to PH_U, any pending strobe is cancelled. No pixel is emitted for the partial quad.
- Back-to-back quads: a U accepted on the first non-busy edge after Y1 starts the new quad. The previous pixel-1 strobe still fires on its own cycle.

Test Plan:
- Neutral gray: quad 00,80,00,80 with continuous in_en -> two strobes, each rgb_out=808080. Strobes land 1 cycle after the V accept and 1 cycle after the Y1 accept; busy is high exactly one cycle after Y1.
- Positive clamp: U=00, Y0=80, V=7F, Y1=00 -> pixel0=FF2580 (R clamped from 306, G=37). Pixel1 = Y 0 with the same U/V: R=178 (B2), G=0 (clamped, -91), B=0 -> B20000.
- Negative clamp: U=80, Y0=00, V=00, Y1=FF -> pixel0=002C00 (B clamped to 0, G=44). Pixel1: R=255, G=255 (clamped), B=255-227=28 -> FFFF1C.
- Handshake: hold in_en=1 while busy=1 with a garbage byte, then present the next U -> garbage is not captured, and the next quad output is correct. Drop in_en mid-quad for 3 cycles -> phase holds and outputs are unaffected.
- Reset mid-operation: assert reset after U,Y0 are accepted -> out_valid=0 and rgb_out=000000 immediately; busy=1. After release, a full fresh quad produces correct pixels with no stale-data strobe.
- Stream: 500 random pixel pairs from a golden file -> exactly 1000 strobes, zero mismatches against the bit-exact fixed-point model above.
